// File: rtl/regfile_pkg.sv
// Shared register-file definitions: architectural register numbers, reset
// values and index-width helper used by the register file and decode logic.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h8002_03FF;
  localparam logic [31:0] RA_INIT_DEFAULT = 32'hDEAD_BEEF;

  function automatic int idx_width(input int size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy scoreboard: producers mark their destination busy at issue,
// writeback clears it, and decode looks up the post-update state of its sources.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int NREAD = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          set_en,
  input  logic [$clog2(SIZE)-1:0]       set_idx,
  input  logic [SIZE-1:0]               clr_vec,
  input  logic [NREAD*$clog2(SIZE)-1:0] rd_idx,
  output logic [NREAD-1:0]              rd_busy_next
);

  localparam int IW = idx_width(SIZE);

  logic [SIZE-1:0] busy;
  logic [SIZE-1:0] busy_next;

  // A set lands after the clear so a newer producer stays outstanding.
  always_comb begin
    busy_next = busy & ~clr_vec;
    if (set_en && (set_idx != '0)) begin
      busy_next[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    rd_busy_next = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_busy_next[k] = busy_next[rd_idx[k*IW +: IW]];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port MIPS register file with write-first registered reads and a busy
// scoreboard for RAW hazard detection in decode.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int               SIZE    = 32,
  parameter int               WIDTH   = 32,
  parameter int               NREAD   = 2,
  parameter int               NWRITE  = 2,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEFAULT),
  parameter logic [WIDTH-1:0] RA_INIT = WIDTH'(RA_INIT_DEFAULT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREAD*$clog2(SIZE)-1:0]  rd_idx,
  output logic [NREAD*WIDTH-1:0]         rd_data,
  output logic [NREAD-1:0]               rd_busy,
  input  logic [NWRITE-1:0]              wr_en,
  input  logic [NWRITE*$clog2(SIZE)-1:0] wr_idx,
  input  logic [NWRITE*WIDTH-1:0]        wr_data,
  input  logic                           set_en,
  input  logic [$clog2(SIZE)-1:0]        set_idx
);

  localparam int IW = idx_width(SIZE);

  logic [WIDTH-1:0] regs      [SIZE];
  logic [WIDTH-1:0] regs_next [SIZE];
  logic [SIZE-1:0]  clr_vec;
  logic [NREAD-1:0] busy_lookup;

  // Ports are applied in ascending order so the highest-numbered port wins.
  always_comb begin
    regs_next = regs;
    clr_vec   = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && (wr_idx[j*IW +: IW] != '0)) begin
        regs_next[wr_idx[j*IW +: IW]] = wr_data[j*WIDTH +: WIDTH];
        clr_vec[wr_idx[j*IW +: IW]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        if (i == REG_SP) begin
          regs[i] <= SP_INIT;
        end else if (i == REG_RA) begin
          regs[i] <= RA_INIT;
        end else begin
          regs[i] <= '0;
        end
      end
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        regs[i] <= regs_next[i];
      end
      for (int k = 0; k < NREAD; k++) begin
        rd_data[k*WIDTH +: WIDTH] <= regs_next[rd_idx[k*IW +: IW]];
      end
      rd_busy <= busy_lookup;
    end
  end

  reg_scoreboard #(
    .SIZE  (SIZE),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en       (set_en),
    .set_idx      (set_idx),
    .clr_vec      (clr_vec),
    .rd_idx       (rd_idx),
    .rd_busy_next (busy_lookup)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: a default 2R/2W instance and a wide
// 4R/1W 64-bit instance, driven with directed vectors.
module tb_register_file_mp;

  typedef struct {
    int          cyc;
    int          vec;
    int          port;
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic clk = 1'b0;
  int   cyc_count  = 0;
  int   vec_id     = 0;
  int   vec_count  = 0;
  int   miss_count = 0;

  logic        rst_n_a;
  logic [9:0]  rd_idx_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [1:0]  wr_en_a;
  logic [9:0]  wr_idx_a;
  logic [63:0] wr_data_a;
  logic        set_en_a;
  logic [4:0]  set_idx_a;

  logic         rst_n_b;
  logic [23:0]  rd_idx_b;
  logic [255:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic [0:0]   wr_en_b;
  logic [5:0]   wr_idx_b;
  logic [63:0]  wr_data_b;
  logic         set_en_b;
  logic [5:0]   set_idx_b;

  register_file_mp #(
    .SIZE(32), .WIDTH(32), .NREAD(2), .NWRITE(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .rd_idx(rd_idx_a), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en_a), .wr_idx(wr_idx_a),
    .wr_data(wr_data_a), .set_en(set_en_a), .set_idx(set_idx_a)
  );

  register_file_mp #(
    .SIZE(64), .WIDTH(64), .NREAD(4), .NWRITE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en_b), .wr_idx(wr_idx_b),
    .wr_data(wr_data_b), .set_en(set_en_b), .set_idx(set_idx_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count = cyc_count + 1;

  task automatic checkOutput(input string name, input logic [63:0] got_d,
                             input logic [63:0] exp_d, input logic got_b,
                             input logic exp_b);
    vec_count++;
    if (got_d !== exp_d || got_b !== exp_b) begin
      miss_count++;
      $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
               name, got_d, got_b, exp_d, exp_b);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge captures them.
  task automatic applyStimulus(input int dut, input logic rst, input logic [1:0] wen,
                               input int wi0, input logic [63:0] wd0,
                               input int wi1, input logic [63:0] wd1,
                               input logic sen, input int si,
                               input int r0, input int r1, input int r2, input int r3);
    @(negedge clk);
    vec_id++;
    if (dut == 0) begin
      rst_n_a   = rst;
      wr_en_a   = wen;
      wr_idx_a  = {5'(wi1), 5'(wi0)};
      wr_data_a = {wd1[31:0], wd0[31:0]};
      set_en_a  = sen;
      set_idx_a = 5'(si);
      rd_idx_a  = {5'(r1), 5'(r0)};
    end else begin
      rst_n_b   = rst;
      wr_en_b   = wen[0];
      wr_idx_b  = 6'(wi0);
      wr_data_b = wd0;
      set_en_b  = sen;
      set_idx_b = 6'(si);
      rd_idx_b  = {6'(r3), 6'(r2), 6'(r1), 6'(r0)};
    end
  endtask

  task automatic expect_rd(input int dut, input int port, input logic [63:0] data,
                           input logic busy);
    exp_t e;
    e.cyc  = cyc_count + 1;
    e.vec  = vec_id;
    e.port = port;
    e.data = data;
    e.busy = busy;
    if (dut == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  task automatic exp_a(input logic [63:0] d0, input logic b0,
                       input logic [63:0] d1, input logic b1);
    expect_rd(0, 0, d0, b0);
    expect_rd(0, 1, d1, b1);
  endtask

  task automatic exp_b(input logic [63:0] d0, input logic b0, input logic [63:0] d1,
                       input logic b1, input logic [63:0] d2, input logic b2,
                       input logic [63:0] d3, input logic b3);
    expect_rd(1, 0, d0, b0);
    expect_rd(1, 1, d1, b1);
    expect_rd(1, 2, d2, b2);
    expect_rd(1, 3, d3, b3);
  endtask

  // Registered outputs are stable at the falling edge after capture.
  always @(negedge clk) begin
    exp_t e;
    while (q_a.size() > 0 && q_a[0].cyc <= cyc_count) begin
      e = q_a.pop_front();
      checkOutput($sformatf("A.v%0d.p%0d", e.vec, e.port),
                  {32'h0, rd_data_a[e.port*32 +: 32]}, e.data,
                  rd_busy_a[e.port], e.busy);
    end
    while (q_b.size() > 0 && q_b[0].cyc <= cyc_count) begin
      e = q_b.pop_front();
      checkOutput($sformatf("B.v%0d.p%0d", e.vec, e.port),
                  rd_data_b[e.port*64 +: 64], e.data,
                  rd_busy_b[e.port], e.busy);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_a = 1'b0; rd_idx_a = '0; wr_en_a = '0; wr_idx_a = '0; wr_data_a = '0;
    set_en_a = 1'b0; set_idx_a = '0;
    rst_n_b = 1'b0; rd_idx_b = '0; wr_en_b = '0; wr_idx_b = '0; wr_data_b = '0;
    set_en_b = 1'b0; set_idx_b = '0;

    // Default instance: reset, zero register, bypass, scoreboard, mid-op reset.
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 29, 31, 0, 0);
    exp_a(0, 0, 0, 0);
    applyStimulus(0, 0, 2'b01, 5, 64'h1, 0, 0, 1, 5, 5, 5, 0, 0);
    exp_a(0, 0, 0, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 29, 31, 0, 0);
    exp_a(64'h8002_03FF, 0, 64'hDEAD_BEEF, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    exp_a(0, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 0, 64'h1234_5678, 0, 0, 1, 0, 0, 0, 0, 0);
    exp_a(0, 0, 0, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    exp_a(0, 0, 0, 0);
    applyStimulus(0, 1, 2'b11, 8, 64'hAAAA_0000, 8, 64'h5555_FFFF, 0, 0, 8, 8, 0, 0);
    exp_a(64'h5555_FFFF, 0, 64'h5555_FFFF, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 8, 29, 0, 0);
    exp_a(64'h5555_FFFF, 0, 64'h8002_03FF, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 1, 9, 9, 8, 0, 0);
    exp_a(0, 1, 64'h5555_FFFF, 0);
    applyStimulus(0, 1, 2'b01, 9, 64'h99, 0, 0, 1, 9, 9, 9, 0, 0);
    exp_a(64'h99, 1, 64'h99, 1);
    applyStimulus(0, 1, 2'b01, 9, 64'h999, 0, 0, 0, 0, 9, 8, 0, 0);
    exp_a(64'h999, 0, 64'h5555_FFFF, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0);
    exp_a(64'h999, 0, 64'h999, 0);
    applyStimulus(0, 1, 2'b11, 3, 64'h3333_3333, 4, 64'h4444_4444, 1, 3, 3, 4, 0, 0);
    exp_a(64'h3333_3333, 1, 64'h4444_4444, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 1, 4, 4, 3, 0, 0);
    exp_a(64'h4444_4444, 1, 64'h3333_3333, 1);
    applyStimulus(0, 0, 2'b01, 3, 64'hFFFF_FFFF, 0, 0, 0, 0, 3, 4, 0, 0);
    exp_a(0, 0, 0, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0);
    exp_a(0, 0, 0, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 29, 31, 0, 0);
    exp_a(64'h8002_03FF, 0, 64'hDEAD_BEEF, 0);
    applyStimulus(0, 1, 2'b10, 31, 64'h1111_1111, 31, 64'h0BAD_F00D, 0, 0, 31, 30, 0, 0);
    exp_a(64'h0BAD_F00D, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 30, 64'h7777_7777, 30, 64'h2222_2222, 0, 0, 30, 31, 0, 0);
    exp_a(64'h7777_7777, 0, 64'h0BAD_F00D, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Wide instance: four independent read ports, single write port.
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 29, 31, 5, 63);
    exp_b(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 29, 31, 5, 63);
    exp_b(64'h8002_03FF, 0, 64'hDEAD_BEEF, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 0, 0, 63, 0);
    exp_b(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'b01, 40, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 40, 29, 31, 0);
    exp_b(64'h0123_4567_89AB_CDEF, 0, 64'h8002_03FF, 0, 64'hDEAD_BEEF, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0, 0, 1, 9, 9, 40, 31, 29);
    exp_b(0, 1, 64'h0123_4567_89AB_CDEF, 0, 64'hDEAD_BEEF, 0, 64'h8002_03FF, 0);
    applyStimulus(1, 1, 2'b01, 9, 64'h1111_2222_3333_4444, 0, 0, 1, 9, 9, 9, 40, 0);
    exp_b(64'h1111_2222_3333_4444, 1, 64'h1111_2222_3333_4444, 1,
          64'h0123_4567_89AB_CDEF, 0, 0, 0);
    applyStimulus(1, 1, 2'b01, 9, 64'h5555_6666_7777_8888, 0, 0, 0, 0, 9, 40, 63, 29);
    exp_b(64'h5555_6666_7777_8888, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 64'h8002_03FF, 0);
    applyStimulus(1, 1, 2'b01, 63, 64'hA5A5_A5A5_5A5A_5A5A, 0, 0, 1, 62, 63, 62, 9, 40);
    exp_b(64'hA5A5_A5A5_5A5A_5A5A, 0, 0, 1, 64'h5555_6666_7777_8888, 0,
          64'h0123_4567_89AB_CDEF, 0);
    applyStimulus(1, 0, 2'b01, 40, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 40, 40, 62, 9, 63);
    exp_b(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 40, 62, 29, 63);
    exp_b(0, 0, 0, 0, 64'h8002_03FF, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    vec_count++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miss_count++;
      $display("[TB] FAIL drain: got %0d/%0d pending expectations, expected 0/0",
               q_a.size(), q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
